// File: rtl/aes_seq_ctrl.sv
// AES sequencing controller: orders key expansion and per-block cipher passes.
// Define AES_CTRL_DECRYPT_EN to add an inverse-cipher pass after each cipher pass.
module aes_seq_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_loaded,
  input  logic             data_loaded,
  output logic             kexp_en,
  input  logic             kexp_done,
  output logic             enc_en,
  input  logic             enc_done,
  output logic             dec_en,
  input  logic             dec_done,
  output logic             key_ready,
  output logic             busy,
  output logic             out_valid,
  output logic             error,
  output logic             overrun,
  output logic [CNT_W-1:0] block_count,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_EXPAND    = 3'd1;
  localparam logic [2:0] S_KEY_READY = 3'd2;
  localparam logic [2:0] S_ENCRYPT   = 3'd3;
  localparam logic [2:0] S_DECRYPT   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  localparam int            TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  logic [2:0]       next_state;
  logic [TW-1:0]    timer, timer_d;
  logic             key_pend, key_pend_d;
  logic             data_pend, data_pend_d;
  logic             kexp_en_d, enc_en_d, dec_en_d;
  logic             key_ready_d, busy_d, out_valid_d, error_d, overrun_d;
  logic [CNT_W-1:0] count_d;
  logic             timed_out, entering;

  assign timed_out = (timer == TMO);
  assign entering  = (next_state != state);

  // State register plus every registered output; all outputs come from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      key_pend    <= 1'b0;
      data_pend   <= 1'b0;
      kexp_en     <= 1'b0;
      enc_en      <= 1'b0;
      key_ready   <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      error       <= 1'b0;
      overrun     <= 1'b0;
      block_count <= '0;
    end else begin
      state       <= next_state;
      timer       <= timer_d;
      key_pend    <= key_pend_d;
      data_pend   <= data_pend_d;
      kexp_en     <= kexp_en_d;
      enc_en      <= enc_en_d;
      key_ready   <= key_ready_d;
      busy        <= busy_d;
      out_valid   <= out_valid_d;
      error       <= error_d;
      overrun     <= overrun_d;
      block_count <= count_d;
    end
  end

`ifdef AES_CTRL_DECRYPT_EN
  always_ff @(posedge clk) begin
    if (rst) dec_en <= 1'b0;
    else     dec_en <= dec_en_d;
  end
`else
  logic unused_dec_done;
  assign dec_en          = 1'b0;
  assign unused_dec_done = dec_done ^ dec_en_d;
`endif

  // A done arriving on the timeout cycle is tested first, so it wins.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (key_loaded || key_pend) next_state = S_EXPAND;
      S_EXPAND:    if (kexp_done) next_state = S_KEY_READY;
                   else if (timed_out) next_state = S_ERR;
      S_KEY_READY: if (key_loaded || key_pend) next_state = S_EXPAND;
                   else if (data_loaded || data_pend) next_state = S_ENCRYPT;
`ifdef AES_CTRL_DECRYPT_EN
      S_ENCRYPT:   if (enc_done) next_state = S_DECRYPT;
                   else if (timed_out) next_state = S_ERR;
      S_DECRYPT:   if (dec_done) next_state = S_DONE;
                   else if (timed_out) next_state = S_ERR;
`else
      S_ENCRYPT:   if (enc_done) next_state = S_DONE;
                   else if (timed_out) next_state = S_ERR;
`endif
      S_DONE:      next_state = S_KEY_READY;
      S_ERR:       if (key_loaded || key_pend) next_state = S_EXPAND;
      default:     next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered above.
  always_comb begin
    kexp_en_d   = entering && (next_state == S_EXPAND);
    enc_en_d    = entering && (next_state == S_ENCRYPT);
    dec_en_d    = entering && (next_state == S_DECRYPT);
    busy_d      = next_state inside {S_EXPAND, S_ENCRYPT, S_DECRYPT};
    key_ready_d = next_state inside {S_KEY_READY, S_ENCRYPT, S_DECRYPT, S_DONE};
    out_valid_d = (next_state == S_DONE);
    error_d     = (next_state == S_ERR);
    overrun_d   = overrun | (data_loaded & data_pend);
    count_d     = block_count + ((next_state == S_DONE) ? CNT_W'(1) : CNT_W'(0));

    key_pend_d = key_pend;
    if (key_loaded && (state inside {S_EXPAND, S_ENCRYPT, S_DECRYPT, S_DONE}))
      key_pend_d = 1'b1;
    if (kexp_en_d)
      key_pend_d = 1'b0;

    // A second request while one is pending is dropped; the first is kept.
    data_pend_d = data_pend | (data_loaded && (state != S_KEY_READY));
    if ((state == S_KEY_READY) && (next_state == S_ENCRYPT))
      data_pend_d = 1'b0;
    if (entering && (next_state == S_ERR))
      data_pend_d = 1'b0;

    if (busy_d && entering) timer_d = TW'(1);
    else if (busy_d)        timer_d = timer + TW'(1);
    else                    timer_d = '0;
  end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Bench for aes_seq_ctrl: directed scenarios then random traffic, all checked
// against a phase/age reference model of the sequencing rules.
module tb_aes_seq_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 2;
`ifdef AES_CTRL_DECRYPT_EN
  localparam bit DEC_ON = 1'b1;
`else
  localparam bit DEC_ON = 1'b0;
`endif

  localparam int P_IDLE = 0, P_EXPAND = 1, P_KR = 2, P_ENC = 3, P_DEC = 4, P_DONE = 5, P_ERR = 6;

  logic clk = 1'b0;
  logic rst, key_loaded, data_loaded, kexp_done, enc_done, dec_done;
  logic kexp_en, enc_en, dec_en, key_ready, busy, out_valid, error, overrun;
  logic [CNT_W-1:0] block_count;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // Reference model: current phase, cycles spent in it, and the flags.
  int ph = P_IDLE;
  int age = 0;
  int cnt = 0;
  bit kv = 0, kp = 0, dp = 0, ovr = 0;

  always #5 clk = ~clk;

  aes_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .key_loaded(key_loaded), .data_loaded(data_loaded),
    .kexp_en(kexp_en), .kexp_done(kexp_done), .enc_en(enc_en), .enc_done(enc_done),
    .dec_en(dec_en), .dec_done(dec_done), .key_ready(key_ready), .busy(busy),
    .out_valid(out_valid), .error(error), .overrun(overrun),
    .block_count(block_count), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit kl, input bit dl,
                            input bit kd, input bit ed, input bit dd);
    int nph;
    bit to;
    if (r) begin
      ph = P_IDLE; age = 0; kv = 0; kp = 0; dp = 0; ovr = 0; cnt = 0;
      return;
    end
    nph = ph;
    to  = (age == TIMEOUT);
    case (ph)
      P_IDLE:   if (kl || kp) nph = P_EXPAND;
      P_EXPAND: if (kd) nph = P_KR; else if (to) nph = P_ERR;
      P_KR:     if (kl || kp) nph = P_EXPAND; else if (dl || dp) nph = P_ENC;
      P_ENC:    if (ed) nph = DEC_ON ? P_DEC : P_DONE; else if (to) nph = P_ERR;
      P_DEC:    if (dd) nph = P_DONE; else if (to) nph = P_ERR;
      P_DONE:   nph = P_KR;
      P_ERR:    if (kl || kp) nph = P_EXPAND;
      default:  nph = P_IDLE;
    endcase
    if (dl && dp) ovr = 1;
    if (kl && !(ph inside {P_IDLE, P_KR, P_ERR})) kp = 1;
    if (dl && ph != P_KR) dp = 1;
    if (nph == P_EXPAND && ph != P_EXPAND) begin kp = 0; kv = 0; end
    if (ph == P_KR && nph == P_ENC) dp = 0;
    if (nph == P_ERR && ph != P_ERR) begin dp = 0; kv = 0; end
    if (ph == P_EXPAND && nph == P_KR) kv = 1;
    if (nph == P_DONE) cnt = (cnt + 1) % (1 << CNT_W);
    age = (nph != ph) ? 1 : age + 1;
    ph  = nph;
  endtask

  task automatic check_model();
    chk("m_kexp_en", kexp_en, (ph == P_EXPAND && age == 1));
    chk("m_enc_en", enc_en, (ph == P_ENC && age == 1));
    chk("m_dec_en", dec_en, (ph == P_DEC && age == 1));
    chk("m_key_ready", key_ready, kv);
    chk("m_busy", busy, (ph inside {P_EXPAND, P_ENC, P_DEC}));
    chk("m_out_valid", out_valid, (ph == P_DONE));
    chk("m_error", error, (ph == P_ERR));
    chk("m_overrun", overrun, ovr);
    chk("m_block_count", block_count, cnt);
    chk("m_state", state, ph);
  endtask

  task automatic step(input bit r, input bit kl, input bit dl,
                      input bit kd, input bit ed, input bit dd);
    rst = r; key_loaded = kl; data_loaded = dl;
    kexp_done = kd; enc_done = ed; dec_done = dd;
    model_step(r, kl, dl, kd, ed, dd);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; key_loaded = 0; data_loaded = 0; kexp_done = 0; enc_done = 0; dec_done = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_state", state, 0);
    chk("rst_outs", {kexp_en, enc_en, dec_en, key_ready, busy, out_valid, error, overrun}, 0);
    chk("rst_count", block_count, 0);

    // Basic block
    idle(7);
    step(0, 1, 0, 0, 0, 0);
    chk("basic_kexp_en", kexp_en, 1);
    chk("basic_expand", state, 1);
    idle(2);
    step(0, 0, 0, 1, 0, 0);
    chk("basic_key_ready", key_ready, 1);
    chk("basic_kr", state, 2);
    idle(3);
    step(0, 0, 1, 0, 0, 0);
    chk("basic_enc_en", enc_en, 1);
    idle(3);
    step(0, 0, 0, 0, 1, 0);
`ifdef AES_CTRL_DECRYPT_EN
    chk("basic_dec_en", dec_en, 1);
    idle(2);
    step(0, 0, 0, 0, 0, 1);
`endif
    chk("basic_out_valid", out_valid, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("basic_count", block_count, 1);
    chk("basic_back_kr", state, 2);

    // Early data during EXPAND, then overrun
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("early_kr", state, 2);
    step(0, 0, 0, 0, 0, 0);
    chk("early_enc_en", enc_en, 1);
    chk("early_no_ovr", overrun, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("overrun_set", overrun, 1);

    // Timeout in ENCRYPT and recovery
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("to_enc_en", enc_en, 1);
    idle(7);
    chk("to_still_enc", state, 3);
    idle(1);
    chk("to_err", state, 6);
    chk("to_error", error, 1);
    chk("to_key_ready", key_ready, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("to_rekey", kexp_en, 1);
    chk("to_error_clr", error, 0);

    // Done on the timeout cycle wins
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(7);
    step(0, 0, 0, 0, 1, 0);
    chk("edge_no_err", error, 0);
    chk("edge_state", state, DEC_ON ? 4 : 5);

    // Re-key mid-block
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
`ifdef AES_CTRL_DECRYPT_EN
    step(0, 0, 0, 0, 0, 1);
`endif
    chk("rekey_out_valid", out_valid, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rekey_kexp_en", kexp_en, 1);

    // Count wrap, then reset during ENCRYPT
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      if (DEC_ON) step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("wrap_count", block_count, (i + 1) % 4);
    end
    step(0, 0, 1, 0, 0, 0);
    chk("rst_mid_enc", state, 3);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_mid_state", state, 0);
    chk("rst_mid_outs", {kexp_en, enc_en, dec_en, key_ready, busy, out_valid, error, overrun}, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(499) == 0),
           ($urandom_range(19) == 0),
           ($urandom_range(7) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
